aq_spsram_1024x16_arb: RTL and testbench

- Shares one 1024x16 single-port SRAM macro wrapper between two requesters, with round-robin arbitration.
- Requester 0: refill/write-dominant side. Requester 1: lookup/read-dominant side.
- After reset, and on demand, runs a hardware init sequence that clears all words to zero before any requester is granted.
- Sits between the requesting pipeline logic and the SRAM wrapper's A/CEN/D/GWEN/WEN/Q pins.

---
 rtl/aq_spsram_arb_pkg.sv | 20 ++
 rtl/aq_spsram_rr_arb2.sv | 35 +++
 rtl/aq_spsram_1024x16_arb.sv | 128 ++++++++++++
 tb/tb_aq_spsram_1024x16_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_spsram_arb_pkg.sv
// rtl/aq_spsram_arb_pkg.sv - shared state encoding and constants for the SRAM arbiter
package aq_spsram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam int RQ0 = 0;
    localparam int RQ1 = 1;

    localparam int unsigned DEF_ADDR_WIDTH = 10;

    function automatic int unsigned init_last(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    localparam int unsigned INIT_LAST = init_last(DEF_ADDR_WIDTH);

endpackage

// File: rtl/aq_spsram_rr_arb2.sv
// rtl/aq_spsram_rr_arb2.sv - two-way round-robin grant with a single pointer flop
module aq_spsram_rr_arb2
    import aq_spsram_arb_pkg::*;
(
    input  logic       forever_cpuclk,
    input  logic       cpurst_b,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // r_ptr names the requester that wins a tie
    logic r_ptr;

    always_comb begin
        gnt = '0;
        if (cpurst_b && en) begin
            if (req == 2'b11) begin
                if (r_ptr) gnt[RQ1] = 1'b1;
                else       gnt[RQ0] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_ptr <= 1'b0;
        end else if (|gnt) begin
            r_ptr <= gnt[RQ0];
        end
    end

endmodule

// File: rtl/aq_spsram_1024x16_arb.sv
// rtl/aq_spsram_1024x16_arb.sv - clear-on-init, round-robin sharing of one single-port SRAM
module aq_spsram_1024x16_arb
    import aq_spsram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  rq0_req,
    input  logic                  rq0_wr,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    input  logic [DATA_WIDTH-1:0] rq0_wmask,
    output logic                  rq0_gnt,
    output logic                  rq0_rvld,
    input  logic                  rq1_req,
    input  logic                  rq1_wr,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    input  logic [DATA_WIDTH-1:0] rq1_wmask,
    output logic                  rq1_gnt,
    output logic                  rq1_rvld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(init_last(ADDR_WIDTH));

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [1:0]            r_rvld;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_run;

    assign w_run = cpurst_b && (r_state == ST_RUN);
    assign w_req = {rq1_req, rq0_req};

    aq_spsram_rr_arb2 u_arb (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req            (w_req),
        .en             (w_run),
        .gnt            (w_gnt)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_rvld  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rvld  <= w_gnt & ~{rq1_wr, rq0_wr};
        end
    end

    // an init_req during INIT restarts the sweep instead of finishing it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (init_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst_b) begin
            if (r_state == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b1;
                sram_wen  = '1;
                sram_a    = r_cnt;
            end else if (w_gnt[RQ0]) begin
                sram_cen  = 1'b0;
                sram_gwen = rq0_wr;
                sram_wen  = rq0_wr ? rq0_wmask : '0;
                sram_a    = rq0_addr;
                sram_d    = rq0_wdata;
            end else if (w_gnt[RQ1]) begin
                sram_cen  = 1'b0;
                sram_gwen = rq1_wr;
                sram_wen  = rq1_wr ? rq1_wmask : '0;
                sram_a    = rq1_addr;
                sram_d    = rq1_wdata;
            end
        end
    end

    assign init_busy = !cpurst_b || (r_state == ST_INIT);
    assign rq0_gnt   = w_gnt[RQ0];
    assign rq1_gnt   = w_gnt[RQ1];
    assign rq0_rvld  = cpurst_b && r_rvld[RQ0];
    assign rq1_rvld  = cpurst_b && r_rvld[RQ1];
    assign rdata     = cpurst_b ? sram_q : '0;

endmodule

// File: tb/tb_aq_spsram_1024x16_arb.sv
// tb/tb_aq_spsram_1024x16_arb.sv - directed bench with per-cycle reference model for the SRAM arbiter
module tb_aq_spsram_1024x16_arb;

    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b, init_req, init_busy;
    logic          rq0_req, rq0_wr, rq0_gnt, rq0_rvld;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_wdata, rq0_wmask;
    logic          rq1_req, rq1_wr, rq1_gnt, rq1_rvld;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_wdata, rq1_wmask;
    logic [DW-1:0] rdata, sram_d, sram_wen, sram_q;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;

    aq_spsram_1024x16_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .init_req       (init_req),
        .init_busy      (init_busy),
        .rq0_req        (rq0_req),
        .rq0_wr         (rq0_wr),
        .rq0_addr       (rq0_addr),
        .rq0_wdata      (rq0_wdata),
        .rq0_wmask      (rq0_wmask),
        .rq0_gnt        (rq0_gnt),
        .rq0_rvld       (rq0_rvld),
        .rq1_req        (rq1_req),
        .rq1_wr         (rq1_wr),
        .rq1_addr       (rq1_addr),
        .rq1_wdata      (rq1_wdata),
        .rq1_wmask      (rq1_wmask),
        .rq1_gnt        (rq1_gnt),
        .rq1_rvld       (rq1_rvld),
        .rdata          (rdata),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_d         (sram_d),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_q         (sram_q)
    );

    // stand-in for the SRAM macro
    logic [DW-1:0] sram_mem [1024];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            else           sram_q <= sram_mem[sram_a];
        end
    end

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // reference model: abstract memory contents plus sweep position, tie pointer, pending read
    bit            m_init;
    logic [AW-1:0] m_addr;
    int            m_ptr;
    logic [1:0]    m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_mem [1024];

    logic [1:0]    s_gnt, s_rvld;
    logic [DW-1:0] s_rdata;
    logic [AW-1:0] s_a;
    logic          s_busy, s_cen, s_gwen;

    task automatic model_cycle();
        logic          e_cen, e_gwen, e_busy, c_wr;
        logic [DW-1:0] e_wen, e_d, e_rdata, nxt_data, c_data, c_mask;
        logic [AW-1:0] e_a, c_addr;
        logic [1:0]    e_gnt, e_rvld, nxt_pend;
        int            w;
        e_cen = 1'b1; e_gwen = 1'b0; e_wen = '0; e_a = '0; e_d = '0;
        e_gnt = '0; e_rvld = '0; e_busy = 1'b1; e_rdata = m_pend_data;
        nxt_pend = '0; nxt_data = '0;
        if (!rst_b) begin
            m_init = 1'b1; m_addr = '0; m_ptr = 0;
        end else begin
            e_rvld = m_pend;
            if (m_init) begin
                e_cen = 1'b0; e_gwen = 1'b1; e_wen = 16'hFFFF; e_a = m_addr;
                m_mem[m_addr] = '0;
                if (init_req)                m_addr = '0;
                else if (m_addr == 10'd1023) begin m_init = 1'b0; m_addr = '0; end
                else                         m_addr = m_addr + 10'd1;
            end else begin
                e_busy = 1'b0;
                w = -1;
                if (rq0_req && rq1_req) w = m_ptr;
                else if (rq0_req)       w = 0;
                else if (rq1_req)       w = 1;
                if (w >= 0) begin
                    c_wr   = (w == 1) ? rq1_wr    : rq0_wr;
                    c_addr = (w == 1) ? rq1_addr  : rq0_addr;
                    c_data = (w == 1) ? rq1_wdata : rq0_wdata;
                    c_mask = (w == 1) ? rq1_wmask : rq0_wmask;
                    e_gnt[w] = 1'b1;
                    e_cen = 1'b0; e_a = c_addr; e_d = c_data;
                    if (c_wr) begin
                        e_gwen = 1'b1; e_wen = c_mask;
                        m_mem[c_addr] = (m_mem[c_addr] & ~c_mask) | (c_data & c_mask);
                    end else begin
                        nxt_pend[w] = 1'b1;
                        nxt_data    = m_mem[c_addr];
                    end
                    m_ptr = 1 - w;
                end
                if (init_req) begin m_init = 1'b1; m_addr = '0; end
            end
        end
        check("sram_cen",  32'(sram_cen),  32'(e_cen));
        check("sram_gwen", 32'(sram_gwen), 32'(e_gwen));
        check("sram_wen",  32'(sram_wen),  32'(e_wen));
        check("sram_a",    32'(sram_a),    32'(e_a));
        check("sram_d",    32'(sram_d),    32'(e_d));
        check("gnt",       32'({rq1_gnt, rq0_gnt}),   32'(e_gnt));
        check("rvld",      32'({rq1_rvld, rq0_rvld}), 32'(e_rvld));
        check("init_busy", 32'(init_busy), 32'(e_busy));
        if (e_rvld != 2'b00) check("rdata", 32'(rdata), 32'(e_rdata));
        m_pend      = nxt_pend;
        m_pend_data = nxt_data;
        s_gnt = {rq1_gnt, rq0_gnt}; s_rvld = {rq1_rvld, rq0_rvld}; s_rdata = rdata;
        s_a = sram_a; s_busy = init_busy; s_cen = sram_cen; s_gwen = sram_gwen;
    endtask

    task automatic step();
        cyc++;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int rq, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] mask,
                          output logic [DW-1:0] rd);
        bit ok = 1'b0;
        if (rq == 0) begin rq0_wr = wr; rq0_addr = addr; rq0_wdata = data; rq0_wmask = mask; rq0_req = 1'b1; end
        else         begin rq1_wr = wr; rq1_addr = addr; rq1_wdata = data; rq1_wmask = mask; rq1_req = 1'b1; end
        for (int i = 0; i < 2000; i++) begin
            step();
            if (s_gnt[rq]) begin ok = 1'b1; break; end
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
        check("access_gnt", 32'(ok), 32'd1);
        rd = '0;
        if (ok && !wr) begin
            step();
            check("access_rvld", 32'(s_rvld[rq]), 32'd1);
            rd = s_rdata;
        end
    endtask

    logic [DW-1:0] rd;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] r0, r1;
    logic [1:0]    prev_gnt;
    int            first_run, gnt_cyc, n_busy, first_a;

    initial begin
        rst_b = 1'b0; init_req = 1'b0;
        rq0_req = 1'b0; rq0_wr = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_wmask = '0;
        rq1_req = 1'b0; rq1_wr = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_wmask = '0;
        m_init = 1'b1; m_addr = '0; m_ptr = 0; m_pend = '0; m_pend_data = '0;

        step();
        step();
        check("reset_cen",  32'(s_cen),  32'd1);
        check("reset_busy", 32'(s_busy), 32'd1);

        // reset release: rq0 read waits out the full clear
        rst_b = 1'b1; cyc = 0;
        rq0_req = 1'b1; rq0_wr = 1'b0; rq0_addr = 10'h000;
        first_run = -1; gnt_cyc = -1;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!s_busy && first_run < 0) first_run = cyc;
            if (s_gnt[0]) begin gnt_cyc = cyc; break; end
        end
        rq0_req = 1'b0;
        check("init_busy_fall_cycle", 32'(first_run), 32'd1025);
        check("rq0_first_gnt_cycle",  32'(gnt_cyc),   32'd1025);
        step();

        access(1, 1'b0, 10'h3FF, 16'h0, 16'h0, rd);
        check("read_3ff", 32'(rd), 32'h0000);

        access(0, 1'b1, 10'h1A5, 16'hBEEF, 16'hFFFF, rd);
        access(0, 1'b1, 10'h1A5, 16'h1234, 16'h00FF, rd);
        access(1, 1'b0, 10'h1A5, 16'h0, 16'h0, rd);
        check("masked_merge", 32'(rd), 32'hBE34);

        for (int i = 0; i < 3; i++) access(0, 1'b1, 10'h010 + 10'(i), 16'h1000 + 16'(i), 16'hFFFF, rd);
        for (int i = 0; i < 3; i++) access(1, 1'b1, 10'h020 + 10'(i), 16'h2000 + 16'(i), 16'hFFFF, rd);

        // both hold reads: grants alternate starting from rq0
        a0 = 10'h010; a1 = 10'h020; r0 = '0; r1 = '0; prev_gnt = '0;
        rq0_wr = 1'b0; rq1_wr = 1'b0; rq0_addr = a0; rq1_addr = a1;
        rq0_req = 1'b1; rq1_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin rq0_req = 1'b0; rq1_req = 1'b0; end
            step();
            if (i < 6) check("alt_gnt", 32'(s_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("alt_rvld", 32'(s_rvld), 32'(prev_gnt));
            if (s_rvld[0]) begin check("alt_rdata0", 32'(s_rdata), 32'(16'h1000 + r0)); r0 = r0 + 16'd1; end
            if (s_rvld[1]) begin check("alt_rdata1", 32'(s_rdata), 32'(16'h2000 + r1)); r1 = r1 + 16'd1; end
            prev_gnt = s_gnt;
            if (s_gnt[0]) begin a0 = a0 + 10'd1; rq0_addr = a0; end
            if (s_gnt[1]) begin a1 = a1 + 10'd1; rq1_addr = a1; end
        end

        // init_req in the same cycle as a read grant
        access(0, 1'b1, 10'h055, 16'hBEEF, 16'hFFFF, rd);
        rq1_wr = 1'b0; rq1_addr = 10'h055; rq1_req = 1'b1; init_req = 1'b1;
        step();
        check("initreq_gnt", 32'(s_gnt), 32'd2);
        rq1_req = 1'b0; init_req = 1'b0;
        step();
        check("initreq_rvld",  32'(s_rvld[1]), 32'd1);
        check("initreq_rdata", 32'(s_rdata),   32'hBEEF);
        check("reinit_a0",     32'(s_a),       32'h0);
        check("reinit_busy",   32'(s_busy),    32'd1);
        n_busy = 1;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!s_busy) break;
            n_busy++;
        end
        check("reinit_len", 32'(n_busy), 32'd1024);
        access(1, 1'b0, 10'h055, 16'h0, 16'h0, rd);
        check("reinit_cleared", 32'(rd), 32'h0000);

        // reset mid-INIT at counter 500
        access(0, 1'b1, 10'h033, 16'h5555, 16'hFFFF, rd);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (s_busy && s_a == 10'd499) break;
        end
        check("reached_499", 32'(s_a), 32'd499);
        rst_b = 1'b0;
        step();
        check("midreset_cen",  32'(s_cen),  32'd1);
        check("midreset_busy", 32'(s_busy), 32'd1);
        rst_b = 1'b1;
        rq0_wr = 1'b0; rq0_addr = 10'h033; rq0_req = 1'b1;
        rq1_wr = 1'b0; rq1_addr = 10'h055; rq1_req = 1'b1;
        n_busy = 0; first_a = -1;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!s_busy) break;
            if (n_busy == 0) first_a = int'(s_a);
            n_busy++;
        end
        check("midreset_len",     32'(n_busy),  32'd1024);
        check("midreset_first_a", 32'(first_a), 32'd0);
        check("ptr_reset_gnt",    32'(s_gnt),   32'd1);
        rq0_req = 1'b0;
        step();
        check("post_reset_rvld0",  32'(s_rvld[0]), 32'd1);
        check("post_reset_rdata0", 32'(s_rdata),   32'h0000);
        check("post_reset_gnt1",   32'(s_gnt),     32'd2);
        rq1_req = 1'b0;
        step();
        check("post_reset_rvld1",  32'(s_rvld[1]), 32'd1);
        check("post_reset_rdata1", 32'(s_rdata),   32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
